// File: rtl/snes_bus_responder.sv
// rtl/snes_bus_responder.sv - SNES CPU bus cycle responder (optional stats via SNES_BUS_STATS_EN)
module snes_bus_responder #(
   parameter int          SYNC_STAGES   = 2,
   parameter int          FILTER_CYCLES = 3,
   parameter logic [7:0]  IDLE_DATA     = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] snes_addr_in,
   input  logic        snes_read_in,
   input  logic        snes_write_in,
   input  logic [7:0]  snes_data_in,
   input  logic [7:0]  mem_rd_data,
   input  logic        mem_rd_valid,
   output logic [23:0] cyc_addr,
   output logic        rd_req,
   output logic        wr_req,
   output logic [7:0]  wr_data,
   output logic [7:0]  snes_data_out,
   output logic        snes_databus_oe_n,
   output logic        snes_databus_dir,
   output logic        proto_err
`ifdef SNES_BUS_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic [7:0]  glitch_count
`endif
);

   localparam logic [3:0] FILT    = 4'(FILTER_CYCLES);
   localparam logic [3:0] FILT_M1 = 4'(FILTER_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RD_ACTIVE, WR_ACTIVE} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
   logic [23:0]            addr_sync [SYNC_STAGES];
   logic [7:0]             data_sync [SYNC_STAGES];
   logic                   rd_s, wr_s;
   logic [23:0]            addr_s;
   logic [7:0]             data_s;

   logic [3:0] rd_cnt, wr_cnt;
   logic       rd_on, wr_on, rd_glitch, wr_glitch;
   logic [7:0] shadow;

   logic [23:0] cyc_addr_nxt;
   logic [7:0]  wr_data_nxt;
   logic        rd_req_nxt, wr_req_nxt, oe_n_nxt, dir_nxt, err_nxt;

   assign rd_s   = rd_sync[SYNC_STAGES-1];
   assign wr_s   = wr_sync[SYNC_STAGES-1];
   assign addr_s = addr_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // Strobe counts as asserted on the clk its low run reaches FILTER_CYCLES samples;
   // any high sample deasserts immediately.
   assign rd_on     = !rd_s && (rd_cnt >= FILT_M1);
   assign wr_on     = !wr_s && (wr_cnt >= FILT_M1);
   // A low run that ended before qualifying is a rejected glitch.
   assign rd_glitch = rd_s && (rd_cnt != 4'd0) && (rd_cnt < FILT);
   assign wr_glitch = wr_s && (wr_cnt != 4'd0) && (wr_cnt < FILT);

   // Pin synchronizers; strobes preset to their idle-high level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sync <= '1;
         wr_sync <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= '0;
            data_sync[i] <= '0;
         end
      end else begin
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], snes_read_in};
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], snes_write_in};
         addr_sync[0] <= snes_addr_in;
         data_sync[0] <= snes_data_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= addr_sync[i-1];
            data_sync[i] <= data_sync[i-1];
         end
      end
   end

   // Saturating low-run counters for the deglitch filter.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt <= 4'd0;
         wr_cnt <= 4'd0;
      end else begin
         if (rd_s)               rd_cnt <= 4'd0;
         else if (rd_cnt != FILT) rd_cnt <= rd_cnt + 4'd1;
         if (wr_s)               wr_cnt <= 4'd0;
         else if (wr_cnt != FILT) wr_cnt <= wr_cnt + 4'd1;
      end
   end

   // State register plus registered cycle outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         cyc_addr          <= '0;
         wr_data           <= '0;
         rd_req            <= 1'b0;
         wr_req            <= 1'b0;
         snes_databus_oe_n <= 1'b1;
         snes_databus_dir  <= 1'b0;
         proto_err         <= 1'b0;
      end else begin
         state             <= state_nxt;
         cyc_addr          <= cyc_addr_nxt;
         wr_data           <= wr_data_nxt;
         rd_req            <= rd_req_nxt;
         wr_req            <= wr_req_nxt;
         snes_databus_oe_n <= oe_n_nxt;
         snes_databus_dir  <= dir_nxt;
         proto_err         <= err_nxt;
      end
   end

   // Next-state selection; read wins over a simultaneous write.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rd_on)      state_nxt = RD_ACTIVE;
            else if (wr_on) state_nxt = WR_ACTIVE;
         end
         RD_ACTIVE: if (rd_s) state_nxt = IDLE;
         WR_ACTIVE: if (wr_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Output next-values per state: request pulses, bus buffer control, error flag.
   always_comb begin
      cyc_addr_nxt = cyc_addr;
      wr_data_nxt  = wr_data;
      rd_req_nxt   = 1'b0;
      wr_req_nxt   = 1'b0;
      oe_n_nxt     = snes_databus_oe_n;
      dir_nxt      = snes_databus_dir;
      err_nxt      = proto_err;
      case (state)
         IDLE: begin
            if (rd_on) begin
               cyc_addr_nxt = addr_s;
               rd_req_nxt   = 1'b1;
               oe_n_nxt     = 1'b0;
               dir_nxt      = 1'b1;
               if (wr_on) err_nxt = 1'b1;
            end else if (wr_on) begin
               cyc_addr_nxt = addr_s;
               oe_n_nxt     = 1'b0;
               dir_nxt      = 1'b0;
            end
         end
         RD_ACTIVE: begin
            if (rd_s) begin
               oe_n_nxt = 1'b1;
               dir_nxt  = 1'b0;
            end
            if (wr_on) err_nxt = 1'b1;
         end
         WR_ACTIVE: begin
            if (wr_s) begin
               wr_data_nxt = shadow;
               wr_req_nxt  = 1'b1;
               oe_n_nxt    = 1'b1;
               dir_nxt     = 1'b0;
            end
            if (rd_on) err_nxt = 1'b1;
         end
         default: begin
            oe_n_nxt = 1'b1;
            dir_nxt  = 1'b0;
         end
      endcase
   end

   // Write-data shadow: last synchronized sample before /WR rises.
   always_ff @(posedge clk) begin
      if (rst)
         shadow <= '0;
      else if (state == WR_ACTIVE || (state == IDLE && wr_on && !rd_on))
         shadow <= data_s;
   end

   // Read data capture; late returns still update the value but never drive the bus.
   always_ff @(posedge clk) begin
      if (rst)               snes_data_out <= IDLE_DATA;
      else if (mem_rd_valid) snes_data_out <= mem_rd_data;
   end

`ifdef SNES_BUS_STATS_EN
   // Request and glitch statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count     <= '0;
         wr_count     <= '0;
         glitch_count <= '0;
      end else begin
         if (rd_req) rd_count <= rd_count + 16'd1;
         if (wr_req) wr_count <= wr_count + 16'd1;
         if ((rd_glitch || wr_glitch) && glitch_count != 8'hFF)
            glitch_count <= glitch_count + 8'd1;
      end
   end
`else
   logic unused_glitch;
   assign unused_glitch = rd_glitch ^ wr_glitch;
`endif

endmodule

// File: tb/tb_snes_bus_responder.sv
// tb/tb_snes_bus_responder.sv - directed self-checking bench for snes_bus_responder
`timescale 1ns/1ps
module tb_snes_bus_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] snes_addr_in;
   logic        snes_read_in;
   logic        snes_write_in;
   logic [7:0]  snes_data_in;
   logic [7:0]  mem_rd_data;
   logic        mem_rd_valid;
   logic [23:0] cyc_addr;
   logic        rd_req, wr_req;
   logic [7:0]  wr_data, snes_data_out;
   logic        snes_databus_oe_n, snes_databus_dir, proto_err;
`ifdef SNES_BUS_STATS_EN
   logic [15:0] rd_count, wr_count;
   logic [7:0]  glitch_count;
`endif

   int total = 0;
   int bad   = 0;

   snes_bus_responder dut (
      .clk(clk), .rst(rst),
      .snes_addr_in(snes_addr_in), .snes_read_in(snes_read_in),
      .snes_write_in(snes_write_in), .snes_data_in(snes_data_in),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .cyc_addr(cyc_addr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
      .snes_data_out(snes_data_out), .snes_databus_oe_n(snes_databus_oe_n),
      .snes_databus_dir(snes_databus_dir), .proto_err(proto_err)
`ifdef SNES_BUS_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count), .glitch_count(glitch_count)
`endif
   );

   always #7 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; snes_read_in = 1'b1; snes_write_in = 1'b1;
      snes_addr_in = '0; snes_data_in = '0; mem_rd_data = '0; mem_rd_valid = 1'b0;
      repeat (3) tick();
      total++; if (snes_databus_oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b exp=1", snes_databus_oe_n); end
      total++; if (snes_databus_dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b exp=0", snes_databus_dir); end
      total++; if (rd_req !== 1'b0 || wr_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b%b exp=00", rd_req, wr_req); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", proto_err); end
      total++; if (cyc_addr !== 24'h0 || wr_data !== 8'h00) begin bad++; $display("FAIL reset_regs got=%h/%h exp=0/0", cyc_addr, wr_data); end
      total++; if (snes_data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", snes_data_out); end
      rst = 1'b0;
      repeat (6) tick();
      total++; if (snes_databus_oe_n !== 1'b1 || rd_req !== 1'b0) begin bad++; $display("FAIL idle_quiet got=%b%b exp=10", snes_databus_oe_n, rd_req); end
   endtask

   task automatic test_write();
      int n = 0, lat = -1;
      logic [7:0] got = 8'h00;
      logic dir_seen = 1'b0;
      snes_addr_in = 24'h208000; snes_data_in = 8'h1F; snes_write_in = 1'b0;
      for (int t = 1; t <= 7; t++) begin
         tick();
         if (snes_databus_dir) dir_seen = 1'b1;
         if (t == 6) begin
            total++; if (snes_databus_oe_n !== 1'b0) begin bad++; $display("FAIL wr_oe_active got=%b exp=0", snes_databus_oe_n); end
         end
      end
      snes_write_in = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (snes_databus_dir) dir_seen = 1'b1;
         if (rd_req) begin bad++; total++; $display("FAIL wr_spurious_rd got=1 exp=0"); end
         if (wr_req) begin n++; lat = t; got = wr_data; end
      end
      total++; if (n != 1) begin bad++; $display("FAIL wr_pulses got=%0d exp=1", n); end
      total++; if (lat != 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      total++; if (got !== 8'h1F) begin bad++; $display("FAIL wr_data got=%h exp=1f", got); end
      total++; if (cyc_addr !== 24'h208000) begin bad++; $display("FAIL wr_addr got=%h exp=208000", cyc_addr); end
      total++; if (dir_seen !== 1'b0) begin bad++; $display("FAIL wr_dir got=%b exp=0", dir_seen); end
      total++; if (snes_databus_oe_n !== 1'b1) begin bad++; $display("FAIL wr_oe_release got=%b exp=1", snes_databus_oe_n); end
   endtask

   task automatic test_glitch();
      int n = 0;
      logic oe_seen = 1'b0;
      snes_addr_in = 24'h00ABCD;
      snes_read_in = 1'b0;
      repeat (2) tick();
      snes_read_in = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (rd_req) n++;
         if (!snes_databus_oe_n) oe_seen = 1'b1;
      end
      total++; if (n != 0) begin bad++; $display("FAIL glitch_rd_req got=%0d exp=0", n); end
      total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL glitch_bus_driven got=%b exp=0", oe_seen); end
`ifdef SNES_BUS_STATS_EN
      total++; if (glitch_count !== 8'd1) begin bad++; $display("FAIL glitch_count got=%0d exp=1", glitch_count); end
`endif
   endtask

   task automatic test_read();
      int pulses = 0;
      for (int i = 0; i < 4096; i++) begin
         int vcnt = -1, req_t = -1, n = 0, extra = 0;
         snes_addr_in = 24'h7E0000 + 24'(i);
         snes_read_in = 1'b0;
         for (int c = 1; c <= 10; c++) begin
            tick();
            mem_rd_valid = 1'b0;
            if (rd_req) begin
               n++; req_t = c; vcnt = 2;
            end else if (vcnt > 0) begin
               vcnt--;
               if (vcnt == 0) begin mem_rd_valid = 1'b1; mem_rd_data = 8'(i); end
            end
         end
         pulses += n;
         total++; if (n != 1 || req_t != 5) begin bad++; $display("FAIL rd_req_timing i=%0d got=%0d@%0d exp=1@5", i, n, req_t); end
         total++; if (snes_data_out !== 8'(i)) begin bad++; $display("FAIL rd_data i=%0d got=%h exp=%h", i, snes_data_out, 8'(i)); end
         total++; if (snes_databus_dir !== 1'b1 || snes_databus_oe_n !== 1'b0) begin bad++; $display("FAIL rd_bus_drive i=%0d got=dir%b oe_n%b exp=dir1 oe_n0", i, snes_databus_dir, snes_databus_oe_n); end
         total++; if (cyc_addr !== 24'h7E0000 + 24'(i)) begin bad++; $display("FAIL rd_addr i=%0d got=%h exp=%h", i, cyc_addr, 24'h7E0000 + 24'(i)); end
         snes_read_in = 1'b1;
         for (int c = 1; c <= 10; c++) begin
            tick();
            mem_rd_valid = 1'b0;
            if (rd_req) extra++;
         end
         pulses += extra;
         total++; if (snes_databus_dir !== 1'b0 || snes_databus_oe_n !== 1'b1 || extra != 0) begin bad++; $display("FAIL rd_release i=%0d got=dir%b oe_n%b extra%0d exp=dir0 oe_n1 extra0", i, snes_databus_dir, snes_databus_oe_n, extra); end
      end
      total++; if (pulses != 4096) begin bad++; $display("FAIL rd_pulse_total got=%0d exp=4096", pulses); end
`ifdef SNES_BUS_STATS_EN
      total++; if (rd_count !== 16'd4096 || wr_count !== 16'd1) begin bad++; $display("FAIL stats_counts got=%0d/%0d exp=4096/1", rd_count, wr_count); end
`endif
   endtask

   task automatic test_simultaneous();
      int nr = 0, nw = 0;
      snes_addr_in = 24'h001234;
      snes_read_in = 1'b0; snes_write_in = 1'b0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (rd_req) nr++;
         if (wr_req) nw++;
      end
      total++; if (snes_databus_dir !== 1'b1 || snes_databus_oe_n !== 1'b0) begin bad++; $display("FAIL sim_bus got=dir%b oe_n%b exp=dir1 oe_n0", snes_databus_dir, snes_databus_oe_n); end
      snes_read_in = 1'b1; snes_write_in = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (rd_req) nr++;
         if (wr_req) nw++;
      end
      total++; if (nr != 1) begin bad++; $display("FAIL sim_rd_pulses got=%0d exp=1", nr); end
      total++; if (nw != 0) begin bad++; $display("FAIL sim_wr_pulses got=%0d exp=0", nw); end
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL sim_proto_err got=%b exp=1", proto_err); end
   endtask

   task automatic test_reset_mid_write();
      int nw = 0;
      snes_addr_in = 24'h123456; snes_data_in = 8'hA5; snes_write_in = 1'b0;
      repeat (7) tick();
      total++; if (snes_databus_oe_n !== 1'b0) begin bad++; $display("FAIL rmw_in_write got=%b exp=0", snes_databus_oe_n); end
      rst = 1'b1;
      tick();
      total++; if (snes_databus_oe_n !== 1'b1 || snes_databus_dir !== 1'b0) begin bad++; $display("FAIL rmw_release got=oe_n%b dir%b exp=oe_n1 dir0", snes_databus_oe_n, snes_databus_dir); end
      tick();
      rst = 1'b0; snes_write_in = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (wr_req || rd_req) nw++;
      end
      total++; if (nw != 0) begin bad++; $display("FAIL rmw_pulses got=%0d exp=0", nw); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rmw_err got=%b exp=0", proto_err); end
      total++; if (cyc_addr !== 24'h0 || wr_data !== 8'h00 || snes_data_out !== 8'h00) begin bad++; $display("FAIL rmw_regs got=%h/%h/%h exp=0/0/0", cyc_addr, wr_data, snes_data_out); end
      total++; if (snes_databus_oe_n !== 1'b1 || snes_databus_dir !== 1'b0) begin bad++; $display("FAIL rmw_bus got=oe_n%b dir%b exp=oe_n1 dir0", snes_databus_oe_n, snes_databus_dir); end
`ifdef SNES_BUS_STATS_EN
      total++; if (rd_count !== 16'd0 || wr_count !== 16'd0 || glitch_count !== 8'd0) begin bad++; $display("FAIL rmw_stats got=%0d/%0d/%0d exp=0/0/0", rd_count, wr_count, glitch_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_glitch();
      test_read();
      test_simultaneous();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snes_bus_responder.md
Name: snes_bus_responder

Overview:
- FPGA-side responder for SNES CPU bus cycles. It is the synthesizable counterpart of the bench-side SNES initiator that drives SNES_ADDR, SNES_READ, SNES_WRITE and SNES_DATA.
- Synchronizes and deglitches the asynchronous bus strobes, then latches address and write data.
- Issues one-clock read/write requests to the memory arbiter and drives read data back onto SNES_DATA with correct buffer OE/DIR.
- Sits between the top-level SNES pins and the address decoder/memory arbiter in main.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on snes_read_in, snes_write_in, snes_addr_in and snes_data_in; legal range 2..4.
- FILTER_CYCLES, 3: consecutive synchronized-low samples required before a strobe counts as asserted; legal range 1..15.
- IDLE_DATA, 8'h00: value on snes_data_out when no read data has been captured since reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- snes_addr_in  in  24  raw SNES address bus.
- snes_read_in  in  1  raw /RD, active low.
- snes_write_in  in  1  raw /WR, active low.
- snes_data_in  in  8  SNES data bus, sampled during writes.
- mem_rd_data  in  8  read data returned by the arbiter.
- mem_rd_valid  in  1  one-clock qualifier for mem_rd_data.
- cyc_addr  out  24  address latched at cycle acceptance.
- rd_req  out  1  one-clock pulse per accepted read.
- wr_req  out  1  one-clock pulse per completed write.
- wr_data  out  8  write data, valid with wr_req.
- snes_data_out  out  8  data driven to SNES during reads.
- snes_databus_oe_n  out  1  level-shifter enable, active low.
- snes_databus_dir  out  1  1 = FPGA drives SNES, 0 = SNES drives FPGA.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values:
  - cyc_addr = 0, wr_data = 0, snes_data_out = IDLE_DATA.
  - rd_req = 0, wr_req = 0, proto_err = 0.
  - snes_databus_oe_n = 1, snes_databus_dir = 0.
  - Synchronizers are preset to strobes high and address/data 0. Filter counters are cleared. State = IDLE.
- Synchronization: all pin inputs pass through SYNC_STAGES flops. Only synchronized values are used.
- Filter: a per-strobe saturating counter increments while the synchronized strobe is low and clears on high. The strobe counts as asserted when the counter reaches FILTER_CYCLES. Deassertion is immediate on the first synchronized high.
- FSM states: IDLE, RD_ACTIVE, WR_ACTIVE.
- IDLE:
  - Read asserted: latch cyc_addr from the synchronized address; pulse rd_req for exactly 1 clk; set oe_n = 0 and dir = 1; go to RD_ACTIVE.
  - Write asserted: latch cyc_addr; set oe_n = 0 and dir = 0; go to WR_ACTIVE.
  - Both asserted in the same clk: read takes priority, the write is ignored for this cycle, and proto_err is set.
- RD_ACTIVE:
  - Each mem_rd_valid loads snes_data_out <= mem_rd_data. The last value is held until the next capture.
  - On synchronized read high: oe_n = 1 and dir = 0 in the same clk; go to IDLE.
  - Write asserted while in this state: set proto_err and keep the read.
- WR_ACTIVE:
  - Capture the synchronized snes_data_in into a shadow register every clk.
  - On synchronized write high: wr_data <= shadow value from the previous clk (last sample before the edge); pulse wr_req for 1 clk; oe_n = 1; go to IDLE.
  - Read asserted while in this state: set proto_err, stay in WR_ACTIVE.
- Latency:
  - Pin falling edge to rd_req = SYNC_STAGES + FILTER_CYCLES clks (5 with defaults).
  - Pin rising edge of /WR to wr_req = SYNC_STAGES + 1 clks.
- Read data from a late mem_rd_valid: if it arrives after the read ends, it still updates snes_data_out, but the bus is not driven.
- Back-to-back cycles: a new cycle is accepted no earlier than the clk after returning to IDLE. No request is ever lost or merged.
- Pulses: rd_req and wr_req are never asserted together.
- Reset mid-cycle: the bus is released in the reset clk. Any pending request is dropped and no pulse is emitted afterwards.

Optional Feature:
- Macro: SNES_BUS_STATS_EN.
- When defined, three extra outputs are added:
  - rd_count[15:0]: wrapping count of rd_req pulses.
  - wr_count[15:0]: wrapping count of wr_req pulses.
  - glitch_count[7:0]: saturating count of low pulses rejected by the filter (strobe high again before reaching FILTER_CYCLES).
- All three clear on rst.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Write cycle: addr 24'h208000, data 8'h1F, /WR low for 100 ns -> wr_req pulses once, wr_data = 8'h1F, cyc_addr = 24'h208000, dir stays 0, oe_n returns to 1.
- Read cycle: 4096 /RD pulses of 140 ns low / 140 ns high, mem_rd_valid with data = i[7:0] two clks after each rd_req:
  - exactly 4096 rd_req pulses;
  - snes_data_out = i[7:0] before each /RD rising edge;
  - dir = 1 only while reading.
- Glitch rejection: a /RD low pulse of FILTER_CYCLES - 1 clks -> no rd_req, bus stays released; glitch_count = 1 when SNES_BUS_STATS_EN is defined.
- Simultaneous strobes: /RD and /WR go low together -> one rd_req, no wr_req, proto_err = 1 and stays 1 until rst.
- Reset mid-write: rst asserted while in WR_ACTIVE, then /WR released -> no wr_req; oe_n = 1, dir = 0 and all outputs at reset values.
- Counter wrap (SNES_BUS_STATS_EN defined): 65537 reads -> rd_count = 1.
